// File: rtl/bcd_up_timer_pkg.sv
// Shared types and BCD helpers for the two-digit up-counting timer and the
// display helpers that reuse its digit arithmetic.
package bcd_up_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // Advance a {tens, units} BCD pair by one; 99 rolls over to 00.
  function automatic logic [7:0] bcd_pair_inc(input logic [7:0] val);
    logic [7:0] res;
    if (val[3:0] >= BCD_MAX) begin
      if (val[7:4] >= BCD_MAX) begin
        res = 8'h00;
      end else begin
        res = {val[7:4] + 4'd1, 4'd0};
      end
    end else begin
      res = {val[7:4], val[3:0] + 4'd1};
    end
    return res;
  endfunction

  function automatic logic [3:0] bcd_clamp(input logic [3:0] digit);
    logic [3:0] res;
    if (digit > BCD_MAX) begin
      res = BCD_MAX;
    end else begin
      res = digit;
    end
    return res;
  endfunction

endpackage

// File: rtl/bcd_up_timer_tick_gen.sv
// Prescaler: counts enabled cycles and flags the terminal one with tick.
module bcd_up_timer_tick_gen #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  // Terminal-count detect and next prescaler value.
  always_comb begin
    tick  = en && (cnt_q == LAST);
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Prescaler register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/bcd_up_timer.sv
// Two-digit BCD up-counting timer: counts 00 up to a limit latched at start,
// one step per prescaled tick, with pause/resume, clear and a done pulse.
module bcd_up_timer
  import bcd_up_timer_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       pause,
  input  logic       clear,
  input  logic [3:0] limit1,
  input  logic [3:0] limit0,
  output logic [3:0] out1,
  output logic [3:0] out0,
  output logic       running,
  output logic       done
);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] limit_q, limit_d;
  logic       done_q, done_d;
  logic       running_q, running_d;
  logic [7:0] clamped_s;
  logic [7:0] stepped_s;
  logic       tick_en_s;
  logic       tick_clr_s;
  logic       tick_s;

  // Prescaler only runs on plain RUN cycles; start/clear/pause take precedence.
  assign tick_en_s  = (state_q == ST_RUN) && !pause && !start && !clear;
  assign tick_clr_s = clear || start;

  bcd_up_timer_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (tick_en_s),
    .clr  (tick_clr_s),
    .tick (tick_s)
  );

  // Next-state, count, limit latch and done pulse.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    limit_d   = limit_q;
    done_d    = 1'b0;
    clamped_s = {bcd_clamp(limit1), bcd_clamp(limit0)};
    stepped_s = bcd_pair_inc(cnt_q);
    if (clear) begin
      state_d = ST_IDLE;
      cnt_d   = 8'h00;
    end else if (start) begin
      limit_d = clamped_s;
      cnt_d   = 8'h00;
      if (clamped_s == 8'h00) begin
        state_d = ST_DONE;
        done_d  = 1'b1;
      end else begin
        state_d = ST_RUN;
      end
    end else begin
      case (state_q)
        ST_RUN: begin
          if (pause) begin
            state_d = ST_PAUSE;
          end else if (tick_s) begin
            cnt_d = stepped_s;
            if (stepped_s == limit_q) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_RUN;
            end
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_PAUSE: begin
          if (pause) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_PAUSE;
          end
        end
        ST_IDLE:  state_d = ST_IDLE;
        ST_DONE:  state_d = ST_DONE;
        default:  state_d = ST_IDLE;
      endcase
    end
    running_d = (state_d == ST_RUN);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 8'h00;
      limit_q   <= 8'h00;
      done_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      limit_q   <= limit_d;
      done_q    <= done_d;
      running_q <= running_d;
    end
  end

  assign out1    = cnt_q[7:4];
  assign out0    = cnt_q[3:0];
  assign running = running_q;
  assign done    = done_q;

endmodule

// File: tb/tb_bcd_up_timer.sv
// Self-checking bench for bcd_up_timer: a directed vector table on a
// TICK_DIV=1 instance plus hand sequences for pause, boundaries and reset.
module tb_bcd_up_timer;

  typedef struct {
    logic       start;
    logic       pause;
    logic       clear;
    logic [3:0] l1;
    logic [3:0] l0;
    logic [7:0] e_cnt;
    logic       e_run;
    logic       e_done;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       pause;
  logic       clear;
  logic [3:0] limit1;
  logic [3:0] limit0;
  logic [3:0] a_out1, a_out0, b_out1, b_out0;
  logic       a_running, a_done, b_running, b_done;

  int checks = 0;
  int errors = 0;

  vec_t vecs[22];

  always #5 clk = ~clk;

  bcd_up_timer #(.TICK_DIV(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .pause(pause), .clear(clear),
    .limit1(limit1), .limit0(limit0),
    .out1(a_out1), .out0(a_out0), .running(a_running), .done(a_done)
  );

  bcd_up_timer #(.TICK_DIV(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .pause(pause), .clear(clear),
    .limit1(limit1), .limit0(limit0),
    .out1(b_out1), .out0(b_out0), .running(b_running), .done(b_done)
  );

  function automatic vec_t mk(input logic s, input logic p, input logic c,
                              input logic [3:0] l1, input logic [3:0] l0,
                              input logic [7:0] ec, input logic er, input logic ed);
    vec_t v;
    v.start = s; v.pause = p; v.clear = c; v.l1 = l1; v.l0 = l0;
    v.e_cnt = ec; v.e_run = er; v.e_done = ed;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic chk_a(input string nm, input logic [7:0] ec, input logic er, input logic ed);
    chk({nm, " cnt"}, {a_out1, a_out0}, ec);
    chk({nm, " running"}, {7'd0, a_running}, {7'd0, er});
    chk({nm, " done"}, {7'd0, a_done}, {7'd0, ed});
  endtask

  task automatic chk_b(input string nm, input logic [7:0] ec, input logic er, input logic ed);
    chk({nm, " cnt"}, {b_out1, b_out0}, ec);
    chk({nm, " running"}, {7'd0, b_running}, {7'd0, er});
    chk({nm, " done"}, {7'd0, b_done}, {7'd0, ed});
  endtask

  task automatic idle_in();
    start = 1'b0; pause = 1'b0; clear = 1'b0;
  endtask

  task automatic do_reset();
    idle_in();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    int act;
    logic [7:0] e;

    // Vector table for the TICK_DIV=1 instance.
    vecs[0] = mk(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 8'h00, 1'b0, 1'b0);
    vecs[1] = mk(1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 8'h00, 1'b0, 1'b0);
    vecs[2] = mk(1'b1, 1'b0, 1'b0, 4'd1, 4'd2, 8'h00, 1'b1, 1'b0);
    for (int i = 1; i <= 11; i++) begin
      vecs[2 + i] = mk(1'b0, 1'b0, 1'b0, 4'd7, 4'd7,
                       {4'(i / 10), 4'(i % 10)}, 1'b1, 1'b0);
    end
    vecs[14] = mk(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 8'h12, 1'b0, 1'b1);
    vecs[15] = mk(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 8'h12, 1'b0, 1'b0);
    vecs[16] = mk(1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 8'h12, 1'b0, 1'b0);
    vecs[17] = mk(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 8'h00, 1'b0, 1'b1);
    vecs[18] = mk(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 8'h00, 1'b0, 1'b0);
    vecs[19] = mk(1'b1, 1'b0, 1'b0, 4'hF, 4'hA, 8'h00, 1'b1, 1'b0);
    vecs[20] = mk(1'b1, 1'b0, 1'b1, 4'd3, 4'd3, 8'h00, 1'b0, 1'b0);
    vecs[21] = mk(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 8'h00, 1'b0, 1'b0);

    limit1 = 4'd0;
    limit0 = 4'd0;
    do_reset();
    chk_a("reset a", 8'h00, 1'b0, 1'b0);
    chk_b("reset b", 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step();
    chk_a("idle5", 8'h00, 1'b0, 1'b0);

    for (int i = 0; i < 22; i++) begin
      start = vecs[i].start; pause = vecs[i].pause; clear = vecs[i].clear;
      limit1 = vecs[i].l1; limit0 = vecs[i].l0;
      step();
      chk_a($sformatf("vec%0d", i), vecs[i].e_cnt, vecs[i].e_run, vecs[i].e_done);
    end
    idle_in();
    for (int i = 0; i < 20; i++) step();
    chk_a("idle after clear+start", 8'h00, 1'b0, 1'b0);

    // Limit 12 done holds 12 for 20 cycles.
    limit1 = 4'd1; limit0 = 4'd2; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 12; i++) step();
    chk_a("hit12", 8'h12, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      step();
      chk_a("hold12", 8'h12, 1'b0, 1'b0);
    end

    // Clamped limit 0xF/0xA counts all the way to 99.
    limit1 = 4'hF; limit0 = 4'hA; start = 1'b1;
    step();
    start = 1'b0;
    chk_a("start99", 8'h00, 1'b1, 1'b0);
    for (int k = 1; k <= 99; k++) begin
      step();
      e = {4'(k / 10), 4'(k % 10)};
      chk_a($sformatf("cnt99 k%0d", k), e, (k < 99), (k == 99));
    end
    step();
    chk_a("hold99", 8'h99, 1'b0, 1'b0);

    // TICK_DIV=4, limit 03 with a 10-cycle pause after 5 active cycles.
    do_reset();
    limit1 = 4'd0; limit0 = 4'd3; start = 1'b1;
    step();
    start = 1'b0;
    chk_b("b start", 8'h00, 1'b1, 1'b0);
    act = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      act++;
      chk_b($sformatf("b act%0d", act), {4'd0, 4'(act / 4)}, 1'b1, 1'b0);
    end
    pause = 1'b1;
    step();
    pause = 1'b0;
    chk_b("b paused", 8'h01, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk_b("b frozen", 8'h01, 1'b0, 1'b0);
    end
    pause = 1'b1;
    step();
    pause = 1'b0;
    chk_b("b resumed", 8'h01, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) begin
      step();
      act++;
      chk_b($sformatf("b act%0d", act), {4'd0, 4'(act / 4)}, (act < 12), (act == 12));
    end
    step();
    chk_b("b hold03", 8'h03, 1'b0, 1'b0);

    // Mid-count restart at 07, then clear in RUN.
    limit1 = 4'd2; limit0 = 4'd0; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 7; i++) step();
    chk_a("at07", 8'h07, 1'b1, 1'b0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk_a("restart", 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step();
    chk_a("restart03", 8'h03, 1'b1, 1'b0);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk_a("clear run", 8'h00, 1'b0, 1'b0);
    step();
    chk_a("after clear", 8'h00, 1'b0, 1'b0);

    // Reset pulse at count 45, then a normal count.
    limit1 = 4'd9; limit0 = 4'd9; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 45; i++) step();
    chk_a("at45", 8'h45, 1'b1, 1'b0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk_a("reset45", 8'h00, 1'b0, 1'b0);
    step();
    chk_a("post reset idle", 8'h00, 1'b0, 1'b0);
    limit1 = 4'd0; limit0 = 4'd2; start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk_a("post reset 01", 8'h01, 1'b1, 1'b0);
    step();
    chk_a("post reset 02", 8'h02, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
